// File: rtl/fetch_if.sv
// Fetch-stage signal bundle: hazard controls, redirect, imem port and IF/ID outputs.
interface fetch_if;
    logic        pc_write;
    logic        ifid_write;
    logic        flush;
    logic [15:0] branch_target;
    logic [15:0] imem_data;
    logic [15:0] imem_addr;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc_plus2;
    logic        ifid_valid;
    logic        halted;
    logic [15:0] stall_count;

    modport master (
        output pc_write, ifid_write, flush, branch_target, imem_data,
        input  imem_addr, ifid_instr, ifid_pc_plus2, ifid_valid,
        input  halted, stall_count
    );

    modport slave (
        input  pc_write, ifid_write, flush, branch_target, imem_data,
        output imem_addr, ifid_instr, ifid_pc_plus2, ifid_valid,
        output halted, stall_count
    );
endinterface

// File: rtl/fetch_stage.sv
// WISC instruction fetch: PC, IF/ID register, HLT freeze and stall counter.
module fetch_stage #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
    input  logic   clk,
    input  logic   rst,
    fetch_if.slave f
);
    logic [15:0] pc_q, pc_d, pc_plus2;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pp2_q, pp2_d;
    logic        valid_q, valid_d;
    logic        halt_q, halt_d;
    logic        halt_set;
    logic [15:0] stall_q, stall_d;

    assign pc_plus2 = pc_q + 16'd2;
    assign halt_set = f.ifid_write && !f.flush && !halt_q
                   && (f.imem_data[15:12] == HLT_OPCODE);

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pp2_d   = pp2_q;
        valid_d = valid_q;
        halt_d  = halt_q;
        stall_d = stall_q;

        // the fetching HLT freezes the PC on its own edge
        if (f.flush)
            pc_d = f.branch_target;
        else if (!halt_q && !halt_set && f.pc_write)
            pc_d = pc_plus2;

        if (f.flush) begin
            instr_d = 16'h0000;
            pp2_d   = 16'h0000;
            valid_d = 1'b0;
        end else if (f.ifid_write) begin
            if (halt_q) begin
                instr_d = 16'h0000;
                valid_d = 1'b0;
            end else begin
                instr_d = f.imem_data;
                pp2_d   = pc_plus2;
                valid_d = 1'b1;
            end
        end

        if (f.flush)
            halt_d = 1'b0;
        else if (halt_set)
            halt_d = 1'b1;

        if (!f.pc_write && !f.flush && !halt_q && stall_q != 16'hFFFF)
            stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            instr_q <= 16'h0000;
            pp2_q   <= 16'h0000;
            valid_q <= 1'b0;
            halt_q  <= 1'b0;
            stall_q <= 16'h0000;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pp2_q   <= pp2_d;
            valid_q <= valid_d;
            halt_q  <= halt_d;
            stall_q <= stall_d;
        end
    end

    assign f.imem_addr     = pc_q;
    assign f.ifid_instr    = instr_q;
    assign f.ifid_pc_plus2 = pp2_q;
    assign f.ifid_valid    = valid_q;
    assign f.halted        = halt_q;
    assign f.stall_count   = stall_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed vector bench for fetch_stage.
module tb_fetch_stage;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    fetch_if bus();

    fetch_stage dut (
        .clk (clk),
        .rst (rst),
        .f   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, pw, iw, fl;
        logic [15:0] tgt, imem;
        logic [15:0] e_addr, e_instr, e_pp2;
        logic        e_v, e_h;
        logic [15:0] e_sc;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string nm, input int idx,
                         input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic pw, input logic iw,
                         input logic fl, input logic [15:0] tgt,
                         input logic [15:0] imem);
        rst               = r;
        bus.pc_write      = pw;
        bus.ifid_write    = iw;
        bus.flush         = fl;
        bus.branch_target = tgt;
        bus.imem_data     = imem;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //             rst pw iw fl tgt       imem      addr      instr     pp2       v  h  sc
        tbl.push_back('{1, 1, 1, 0, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'd0});
        tbl.push_back('{0, 1, 1, 0, 16'h0000, 16'h1234, 16'h0002, 16'h1234, 16'h0002, 1, 0, 16'd0});
        tbl.push_back('{0, 1, 1, 0, 16'h0000, 16'h1234, 16'h0004, 16'h1234, 16'h0004, 1, 0, 16'd0});
        tbl.push_back('{0, 1, 1, 0, 16'h0000, 16'h1234, 16'h0006, 16'h1234, 16'h0006, 1, 0, 16'd0});
        tbl.push_back('{0, 0, 0, 0, 16'h0000, 16'h9999, 16'h0006, 16'h1234, 16'h0006, 1, 0, 16'd1});
        tbl.push_back('{0, 0, 0, 0, 16'h0000, 16'h9999, 16'h0006, 16'h1234, 16'h0006, 1, 0, 16'd2});
        tbl.push_back('{0, 1, 1, 0, 16'h0000, 16'h2222, 16'h0008, 16'h2222, 16'h0008, 1, 0, 16'd2});
        tbl.push_back('{0, 1, 1, 0, 16'h0000, 16'h3333, 16'h000A, 16'h3333, 16'h000A, 1, 0, 16'd2});
        tbl.push_back('{0, 0, 0, 1, 16'h0040, 16'h4444, 16'h0040, 16'h0000, 16'h0000, 0, 0, 16'd2});
        tbl.push_back('{0, 1, 1, 0, 16'h0000, 16'h5555, 16'h0042, 16'h5555, 16'h0042, 1, 0, 16'd2});
        tbl.push_back('{0, 1, 1, 1, 16'h0010, 16'hF000, 16'h0010, 16'h0000, 16'h0000, 0, 0, 16'd2});
        tbl.push_back('{0, 1, 1, 0, 16'h0000, 16'hF000, 16'h0010, 16'hF000, 16'h0012, 1, 1, 16'd2});
        tbl.push_back('{0, 1, 1, 0, 16'h0000, 16'h1111, 16'h0010, 16'h0000, 16'h0012, 0, 1, 16'd2});
        tbl.push_back('{0, 0, 0, 0, 16'h0000, 16'h1111, 16'h0010, 16'h0000, 16'h0012, 0, 1, 16'd2});
        tbl.push_back('{0, 0, 1, 1, 16'h0100, 16'hF000, 16'h0100, 16'h0000, 16'h0000, 0, 0, 16'd2});
        tbl.push_back('{0, 1, 1, 0, 16'h0000, 16'h6666, 16'h0102, 16'h6666, 16'h0102, 1, 0, 16'd2});
        tbl.push_back('{0, 1, 1, 1, 16'hFFFE, 16'h0000, 16'hFFFE, 16'h0000, 16'h0000, 0, 0, 16'd2});
        tbl.push_back('{0, 1, 1, 0, 16'h0000, 16'h7777, 16'h0000, 16'h7777, 16'h0000, 1, 0, 16'd2});
        tbl.push_back('{1, 0, 1, 1, 16'h1234, 16'hF000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'd0});

        drive(1, 0, 0, 0, 16'h0000, 16'h0000);
        step();

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].pw, tbl[i].iw, tbl[i].fl,
                  tbl[i].tgt, tbl[i].imem);
            step();
            check("imem_addr", i, bus.imem_addr, tbl[i].e_addr);
            check("ifid_instr", i, bus.ifid_instr, tbl[i].e_instr);
            check("ifid_pc_plus2", i, bus.ifid_pc_plus2, tbl[i].e_pp2);
            check("ifid_valid", i, {15'd0, bus.ifid_valid}, {15'd0, tbl[i].e_v});
            check("halted", i, {15'd0, bus.halted}, {15'd0, tbl[i].e_h});
            check("stall_count", i, bus.stall_count, tbl[i].e_sc);
        end

        // long stall run to saturate the counter
        drive(0, 0, 0, 0, 16'h0000, 16'h1234);
        repeat (65534) @(posedge clk);
        #1;
        check("stall_fffe", 100, bus.stall_count, 16'hFFFE);
        check("stall_pc_hold", 100, bus.imem_addr, 16'h0000);
        step();
        check("stall_ffff", 101, bus.stall_count, 16'hFFFF);
        repeat (3) step();
        check("stall_sat", 102, bus.stall_count, 16'hFFFF);
        check("stall_valid_hold", 102, {15'd0, bus.ifid_valid}, 16'd0);

        drive(0, 1, 1, 0, 16'h0000, 16'h1234);
        step();
        check("resume_addr", 103, bus.imem_addr, 16'h0002);
        check("resume_sc", 103, bus.stall_count, 16'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
